// File: rtl/decode_stage.sv
// Registered RV32I decode stage: decodes the opcode, slices the raw immediate
// fields for the extender, and buffers entries in a 2-entry skid buffer
// (output register + skid register) for full throughput with registered ready.
module decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] pc_o,
  output logic [1:0]      extend_o,
  output logic [19:0]     u_type_o,
  output logic [8:0]      j_type_o,
  output logic [12:0]     b_type_o,
  output logic [11:0]     i_and_s_type_o,
  output logic [4:0]      rd_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [6:0]      opcode_o,
  output logic [2:0]      funct3_o,
  output logic            illegal_o
);

  typedef enum logic [1:0] {
    EXT_U  = 2'b00,
    EXT_J  = 2'b01,
    EXT_B  = 2'b10,
    EXT_IS = 2'b11
  } extend_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // One decoded instruction as held in either buffer slot.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    extend_e         extend;
    logic [19:0]     u_type;
    logic [8:0]      j_type;
    logic [12:0]     b_type;
    logic [11:0]     i_and_s_type;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            illegal;
  } entry_t;

  entry_t dec;
  entry_t or_q, sr_q;
  logic   or_valid_q, sr_valid_q;
  logic   accept, drain;

  // Combinational decode of the incoming instruction; captured only on accept.
  always_comb begin
    // NOTE: every field gets a default first so no path through the case can infer a latch.
    dec              = '0;
    dec.pc           = pc_i;
    dec.u_type       = instr_i[31:12];
    dec.j_type       = {instr_i[31], instr_i[19:12]};
    dec.b_type       = {instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    dec.i_and_s_type = instr_i[31:20];
    dec.rd           = instr_i[11:7];
    dec.rs1          = instr_i[19:15];
    dec.rs2          = instr_i[24:20];
    dec.opcode       = instr_i[6:0];
    dec.funct3       = instr_i[14:12];
    dec.extend       = EXT_IS;
    dec.illegal      = 1'b0;
    case (instr_i[6:0])
      OPC_LUI, OPC_AUIPC: dec.extend = EXT_U;
      OPC_JAL:            dec.extend = EXT_J;
      OPC_BRANCH:         dec.extend = EXT_B;
      OPC_STORE:          dec.i_and_s_type = {instr_i[31:25], instr_i[11:7]};
      OPC_OP_IMM, OPC_LOAD, OPC_JALR,
      OPC_OP, OPC_FENCE, OPC_SYSTEM: dec.extend = EXT_IS;
      default:            dec.illegal = 1'b1;
    endcase
  end

  // Ready depends only on the skid slot, so there is no path from out_ready_i.
  assign in_ready_o = ~sr_valid_q;
  assign accept     = in_valid_i & in_ready_o;
  assign drain      = or_valid_q & out_ready_i;

  // Skid-buffer occupancy and data movement; flush overrides any accept.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      or_valid_q <= 1'b0;
      sr_valid_q <= 1'b0;
      // NOTE: data slots are reset too so every output reads zero out of reset.
      or_q       <= '0;
      sr_q       <= '0;
    end else if (flush_i) begin
      // NOTE: state uses non-blocking assignments so all slots update from pre-edge values.
      or_valid_q <= 1'b0;
      sr_valid_q <= 1'b0;
    end else if (!or_valid_q) begin
      // Skid slot is never occupied while the output slot is empty.
      if (accept) begin
        or_q       <= dec;
        or_valid_q <= 1'b1;
      end
    end else if (drain) begin
      if (sr_valid_q) begin
        // A full skid slot implies no accept this cycle.
        or_q       <= sr_q;
        sr_valid_q <= 1'b0;
      end else if (accept) begin
        or_q <= dec;
      end else begin
        or_valid_q <= 1'b0;
      end
    end else if (accept) begin
      sr_q       <= dec;
      sr_valid_q <= 1'b1;
    end
  end

  assign out_valid_o    = or_valid_q;
  assign pc_o           = or_q.pc;
  assign extend_o       = or_q.extend;
  assign u_type_o       = or_q.u_type;
  assign j_type_o       = or_q.j_type;
  assign b_type_o       = or_q.b_type;
  assign i_and_s_type_o = or_q.i_and_s_type;
  assign rd_o           = or_q.rd;
  assign rs1_o          = or_q.rs1;
  assign rs2_o          = or_q.rs2;
  assign opcode_o       = or_q.opcode;
  assign funct3_o       = or_q.funct3;
  assign illegal_o      = or_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a table of hand-decoded instructions sent
// back to back, plus sequences for stall, flush and asynchronous reset.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] instr_i;
  logic [31:0] pc_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] pc_o;
  logic [1:0]  extend_o;
  logic [19:0] u_type_o;
  logic [8:0]  j_type_o;
  logic [12:0] b_type_o;
  logic [11:0] i_and_s_type_o;
  logic [4:0]  rd_o, rs1_o, rs2_o;
  logic [6:0]  opcode_o;
  logic [2:0]  funct3_o;
  logic        illegal_o;

  int unsigned n_tests = 0;
  int unsigned n_failed = 0;

  decode_stage #(.XLEN(32)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .instr_i(instr_i), .pc_i(pc_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .pc_o(pc_o), .extend_o(extend_o), .u_type_o(u_type_o),
    .j_type_o(j_type_o), .b_type_o(b_type_o), .i_and_s_type_o(i_and_s_type_o),
    .rd_o(rd_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
    .opcode_o(opcode_o), .funct3_o(funct3_o), .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [1:0]  ext;
    logic        ill;
    logic [19:0] imm;   // field selected by ext: u, j, b or i/s
    logic [19:0] u;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  op;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_vec(input int i);
    logic [31:0] imm_act;
    case (vecs[i].ext)
      2'b00:   imm_act = {12'd0, u_type_o};
      2'b01:   imm_act = {23'd0, j_type_o};
      2'b10:   imm_act = {19'd0, b_type_o};
      default: imm_act = {20'd0, i_and_s_type_o};
    endcase
    check($sformatf("v%0d out_valid", i), {31'd0, out_valid_o}, 32'd1);
    check($sformatf("v%0d pc", i), pc_o, vecs[i].pc);
    check($sformatf("v%0d extend", i), {30'd0, extend_o}, {30'd0, vecs[i].ext});
    check($sformatf("v%0d illegal", i), {31'd0, illegal_o}, {31'd0, vecs[i].ill});
    check($sformatf("v%0d imm", i), imm_act, {12'd0, vecs[i].imm});
    check($sformatf("v%0d u_type", i), {12'd0, u_type_o}, {12'd0, vecs[i].u});
    check($sformatf("v%0d rd", i), {27'd0, rd_o}, {27'd0, vecs[i].rd});
    check($sformatf("v%0d rs1", i), {27'd0, rs1_o}, {27'd0, vecs[i].rs1});
    check($sformatf("v%0d rs2", i), {27'd0, rs2_o}, {27'd0, vecs[i].rs2});
    check($sformatf("v%0d funct3", i), {29'd0, funct3_o}, {29'd0, vecs[i].f3});
    check($sformatf("v%0d opcode", i), {25'd0, opcode_o}, {25'd0, vecs[i].op});
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    in_valid_i = v;
    instr_i    = ins;
    pc_i       = pc;
  endtask

  initial begin
    // instr, pc, ext, ill, imm, u, rd, rs1, rs2, f3, op
    vecs[0] = '{32'h123450B7, 32'h100, 2'b00, 1'b0, 20'h12345, 20'h12345, 5'd1,  5'd8,  5'd3,  3'd5, 7'h37}; // LUI x1
    vecs[1] = '{32'hFE000EE3, 32'h104, 2'b10, 1'b0, 20'h01FFC, 20'hFE000, 5'd29, 5'd0,  5'd0,  3'd0, 7'h63}; // BEQ -4
    vecs[2] = '{32'hFFF00093, 32'h108, 2'b11, 1'b0, 20'h00FFF, 20'hFFF00, 5'd1,  5'd0,  5'd31, 3'd0, 7'h13}; // ADDI -1
    vecs[3] = '{32'h0020A423, 32'h10C, 2'b11, 1'b0, 20'h00008, 20'h0020A, 5'd8,  5'd1,  5'd2,  3'd2, 7'h23}; // SW
    vecs[4] = '{32'h801FF0EF, 32'h110, 2'b01, 1'b0, 20'h001FF, 20'h801FF, 5'd1,  5'd31, 5'd1,  3'd7, 7'h6F}; // JAL
    vecs[5] = '{32'h0FF0000F, 32'h114, 2'b11, 1'b0, 20'h000FF, 20'h0FF00, 5'd0,  5'd0,  5'd31, 3'd0, 7'h0F}; // FENCE
    vecs[6] = '{32'h0000007F, 32'h118, 2'b11, 1'b1, 20'h00000, 20'h00000, 5'd0,  5'd0,  5'd0,  3'd0, 7'h7F}; // illegal

    rst_ni      = 1'b0;
    flush_i     = 1'b0;
    out_ready_i = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    #12;
    check("reset out_valid", {31'd0, out_valid_o}, 32'd0);
    check("reset in_ready", {31'd0, in_ready_o}, 32'd1);
    check("reset pc", pc_o, 32'd0);
    check("reset u_type", {12'd0, u_type_o}, 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;

    // Table vectors, back to back: each one checked one cycle after its accept.
    out_ready_i = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i > 0) check_vec(i - 1);
      check($sformatf("v%0d in_ready", i), {31'd0, in_ready_o}, 32'd1);
      drive(1'b1, vecs[i].instr, vecs[i].pc);
    end
    @(negedge clk);
    check_vec(6);
    drive(1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("table drained", {31'd0, out_valid_o}, 32'd0);

    // Stall: A, B accepted, C refused until downstream opens, then strict order.
    out_ready_i = 1'b0;
    drive(1'b1, 32'hFFF00093, 32'h200);
    @(negedge clk);
    check("stall A held", pc_o, 32'h200);
    check("stall ready after A", {31'd0, in_ready_o}, 32'd1);
    drive(1'b1, 32'hFFF00093, 32'h204);
    @(negedge clk);
    check("stall ready during C", {31'd0, in_ready_o}, 32'd0);
    check("stall A still out", pc_o, 32'h200);
    drive(1'b1, 32'hFFF00093, 32'h208);
    @(negedge clk);
    check("stall C refused", {31'd0, in_ready_o}, 32'd0);
    check("stall A after C", pc_o, 32'h200);
    out_ready_i = 1'b1;
    @(negedge clk);
    check("order B valid", {31'd0, out_valid_o}, 32'd1);
    check("order B", pc_o, 32'h204);
    check("order ready", {31'd0, in_ready_o}, 32'd1);
    @(negedge clk);
    check("order C valid", {31'd0, out_valid_o}, 32'd1);
    check("order C", pc_o, 32'h208);
    drive(1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("order empty", {31'd0, out_valid_o}, 32'd0);

    // Flush with both slots full and an input offered.
    out_ready_i = 1'b0;
    drive(1'b1, 32'hFFF00093, 32'h300);
    @(negedge clk);
    drive(1'b1, 32'hFFF00093, 32'h304);
    @(negedge clk);
    check("flush pre full", {31'd0, in_ready_o}, 32'd0);
    drive(1'b1, 32'hFFF00093, 32'h308);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    check("flush full out_valid", {31'd0, out_valid_o}, 32'd0);
    check("flush full in_ready", {31'd0, in_ready_o}, 32'd1);
    @(negedge clk);
    check("flush full stays empty", {31'd0, out_valid_o}, 32'd0);

    // Flush beats an accept that would otherwise load the empty output slot.
    drive(1'b1, 32'hFFF00093, 32'h400);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    check("flush drops input", {31'd0, out_valid_o}, 32'd0);
    @(negedge clk);
    check("flush input never appears", {31'd0, out_valid_o}, 32'd0);

    // Asynchronous reset while two entries are held.
    drive(1'b1, 32'h123450B7, 32'h500);
    @(negedge clk);
    drive(1'b1, 32'h123450B7, 32'h504);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0);
    check("areset pre held", {31'd0, out_valid_o}, 32'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("areset out_valid", {31'd0, out_valid_o}, 32'd0);
    check("areset in_ready", {31'd0, in_ready_o}, 32'd1);
    check("areset pc", pc_o, 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    check("areset stays empty", {31'd0, out_valid_o}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
